icache: RTL
===========

# icache

Direct-mapped, read-only L1 instruction cache between the fetch pipeline's I-mem port and the memory bus. Accepts one 64-bit-aligned fetch request per cycle on hits and returns the containing 64-bit word one cycle later. On a miss it refills a 32-byte line as a 4-beat burst, then responds. A flush input (FENCE.I) invalidates all lines.

## Interface
- CACHE_LINES, 64: number of lines; power of two, ≥2. IDXW = log2(CACHE_LINES).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- im_req_addr  in  64  fetch byte address; bits [2:0] ignored
- im_req_valid  in  1  fetch request valid
- im_req_ready  out  1  request accepted when valid && ready
- im_resp_rdata  out  64  aligned 64-bit word containing the requested address
- im_resp_valid  out  1  one-cycle response pulse; no backpressure, consumer always accepts
- flush  in  1  single-cycle invalidate-all pulse
- mem_req_addr  out  64  line address, bits [4:0] = 0
- mem_req_valid  out  1  refill request valid
- mem_req_ready  in  1  refill request accepted when valid && ready
- mem_resp_rdata  in  64  refill beat data
- mem_resp_valid  in  1  refill beat valid; exactly 4 beats per request, in address order, no gaps required

## Operation
- Address split: beat = addr[4:3], index = addr[5+IDXW-1:5], tag = addr[63:5+IDXW].
- Storage: data RAM CACHE_LINES×4×64 and tag RAM, both synchronous read (1 cycle); valid bits in flops.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE: im_req_ready = !flush_pending. On accept: register address, read tag/data RAM, go LOOKUP.
- LOOKUP: hit = valid[index] && tag match. Hit: im_resp_valid = 1, im_resp_rdata = RAM data, im_req_ready = !flush_pending; new request accepted same cycle stays in LOOKUP, else IDLE. Miss: im_req_ready = 0, go MISS_REQ.
- MISS_REQ: mem_req_valid = 1, mem_req_addr = {req_addr[63:5], 5'b0}; held stable until mem_req_ready, then REFILL with beat counter = 0.
- REFILL: each mem_resp_valid writes data RAM at {index, counter}, counter increments (2-bit, wraps). Beat with counter == requested beat is latched into response register. On 4th beat: write tag, set valid[index], go RESP.
- RESP: im_resp_valid = 1 with latched word; im_req_ready = 0; next state IDLE.
- mem_resp_valid outside REFILL is ignored.
- Flush: in IDLE, all valid bits cleared at next edge. In any other state, flush_pending set; im_req_ready forced 0 while pending; cleared (valids cleared) on the first IDLE cycle. The in-flight request still completes and responds with its fetched data; a line being refilled is written valid, then cleared by the pending flush.
- Flush coincident with refill completion: pending flush wins; line ends invalid.

## Timing
- Reset: state IDLE, all valid bits 0, flush_pending 0, counter 0. During rst: im_req_ready = 0, im_resp_valid = 0, mem_req_valid = 0. im_req_ready = 1 first cycle after rst deasserts.
- Reset mid-refill: abandon refill, line stays invalid; remaining memory beats after reset are ignored.
- Hit latency: accept at cycle T, im_resp_valid at T+1. Back-to-back hits: 1 response per cycle.
- Miss latency: accept T, miss detected T+1, mem_req_valid from T+2, response 1 cycle after 4th beat.
- At most one outstanding refill; im_req_ready low from miss detection through RESP.

## Test plan
- Cold miss: after reset, fetch 0x80000000 → mem_req_addr 0x80000000, feed beats D0..D3 → im_resp_rdata = D0 one cycle after D3, no earlier im_resp_valid.
- Hit stream: then fetch 0x80000004, 0x80000008, 0x80000010, 0x80000018 back-to-back → responses D0, D1, D2, D3 on consecutive cycles, no mem_req_valid.
- Critical word: cold fetch 0x80000218 → mem_req_addr 0x80000200, response = 4th beat.
- Conflict: CACHE_LINES=64, fetch 0x80000800 after 0x80000000 → miss, refill at 0x80000800; re-fetch 0x80000000 → miss again.
- Flush: flush pulse in IDLE then fetch 0x80000000 → miss; flush during REFILL → current response delivered, im_req_ready low until IDLE, subsequent fetch of same line misses.
- Reset after 2 refill beats → im_resp_valid stays 0, next fetch of that line misses and issues a fresh mem_req.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle for the L1 instruction cache.
// The cache binds the slave modport; the fetch pipeline / memory model binds master.
interface icache_if;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic        flush;
  logic [63:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_resp_rdata;
  logic        mem_resp_valid;

  modport slave (
    input  im_req_addr, im_req_valid, flush, mem_req_ready, mem_resp_rdata, mem_resp_valid,
    output im_req_ready, im_resp_rdata, im_resp_valid, mem_req_addr, mem_req_valid
  );

  modport master (
    output im_req_addr, im_req_valid, flush, mem_req_ready, mem_resp_rdata, mem_resp_valid,
    input  im_req_ready, im_resp_rdata, im_resp_valid, mem_req_addr, mem_req_valid
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only L1 instruction cache: 32-byte lines, 64-bit fetch words,
// 4-beat burst refill, invalidate-all on flush (deferred to IDLE while busy).
module icache #(
  parameter int unsigned CACHE_LINES = 64
) (
  input logic   clk,
  input logic   rst,
  icache_if.slave bus
);
  localparam int unsigned IDXW = $clog2(CACHE_LINES);
  localparam int unsigned TAGW = 64 - 5 - IDXW;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;

  state_t                 state, state_nxt;
  logic [63:3]            req_word;
  logic [1:0]             cnt;
  logic                   flush_pending;
  logic [CACHE_LINES-1:0] valid;

  logic [63:0]     data_ram [CACHE_LINES*4];
  logic [TAGW-1:0] tag_ram  [CACHE_LINES];
  logic [63:0]     data_q;
  logic [TAGW-1:0] tag_q;

  logic [IDXW-1:0] req_idx, in_idx;
  logic [TAGW-1:0] req_tag;
  logic [1:0]      req_beat, in_beat;
  logic            hit, accept, beat_in;
  logic            req_ready_c, resp_valid_c, mem_req_valid_c;
  logic            unused_addr_lsb;

  assign req_idx  = req_word[5+IDXW-1:5];
  assign req_tag  = req_word[63:5+IDXW];
  assign req_beat = req_word[4:3];
  assign in_idx   = bus.im_req_addr[5+IDXW-1:5];
  assign in_beat  = bus.im_req_addr[4:3];
  assign unused_addr_lsb = ^bus.im_req_addr[2:0];

  assign hit     = valid[req_idx] && (tag_q == req_tag);
  assign accept  = bus.im_req_valid && req_ready_c;
  assign beat_in = (state == REFILL) && bus.mem_resp_valid;

  assign bus.im_req_ready  = req_ready_c;
  assign bus.im_resp_valid = resp_valid_c;
  assign bus.im_resp_rdata = data_q;
  assign bus.mem_req_valid = mem_req_valid_c;
  assign bus.mem_req_addr  = {req_word[63:5], 5'b0};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; all handshakes held low while in reset
  always_comb begin
    state_nxt       = state;
    req_ready_c     = 1'b0;
    resp_valid_c    = 1'b0;
    mem_req_valid_c = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = !flush_pending;
        if (bus.im_req_valid && !flush_pending) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          resp_valid_c = 1'b1;
          req_ready_c  = !flush_pending;
          state_nxt    = (bus.im_req_valid && !flush_pending) ? LOOKUP : IDLE;
        end else begin
          state_nxt = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid_c = 1'b1;
        if (bus.mem_req_ready) state_nxt = REFILL;
      end
      REFILL: begin
        if (bus.mem_resp_valid && cnt == 2'd3) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_c = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      req_ready_c     = 1'b0;
      resp_valid_c    = 1'b0;
      mem_req_valid_c = 1'b0;
    end
  end

  // Control flops: valid bits, deferred flush, refill beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= '0;
      flush_pending <= 1'b0;
      cnt           <= 2'd0;
    end else begin
      if (state == IDLE) begin
        if (bus.flush || flush_pending) valid <= '0;
        flush_pending <= 1'b0;
      end else if (bus.flush) begin
        flush_pending <= 1'b1;
      end
      if (state == MISS_REQ) cnt <= 2'd0;
      if (beat_in) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) valid[req_idx] <= 1'b1;
      end
    end
  end

  // Request register, synchronous-read RAMs, and the response word register
  always_ff @(posedge clk) begin
    if (accept) begin
      req_word <= bus.im_req_addr[63:3];
      data_q   <= data_ram[{in_idx, in_beat}];
      tag_q    <= tag_ram[in_idx];
    end
    if (beat_in) begin
      data_ram[{req_idx, cnt}] <= bus.mem_resp_rdata;
      if (cnt == req_beat) data_q <= bus.mem_resp_rdata;
      if (cnt == 2'd3) tag_ram[req_idx] <= req_tag;
    end
  end
endmodule
